mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter consuming the MW-stage store bus (ALU address, store data, LSU uart select).
//  Buffers CPU bytes in a TX FIFO, serialises them 8N1 on tx, and exposes a STATUS word for polling loads.
//  Sits directly downstream of the core's execute/memory stage, beside dmem.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); must be >= 2
//  FIFO_DEPTH    16   TX FIFO entries; power of two, >= 2
//  ADDR_WIDTH    32   cpu_address width
//  DATA_WIDTH    32   cpu_wdata / cpu_rdata width
// PORTS
//  clk           in   1           core clock
//  reset         in   1           synchronous, active-high reset
//  cpu_address   in   ADDR_WIDTH  byte address from MW stage; only bits [3:2] are decoded
//  cpu_wdata     in   DATA_WIDTH  store data; bits [7:0] are the TX byte
//  write_enable  in   1           store hits this block (LSU uart select AND MW write enable)
//  read_enable   in   1           load hits this block
//  cpu_rdata     out  DATA_WIDTH  combinational read data; 0 when read_enable=0
//  tx            out  1           serial line, idle high
//  irq_tx_empty  out  1           high while FIFO empty AND shifter idle
// BEHAVIOUR
//  Register map (offset = cpu_address[3:2]):
//   0 TXDATA  W: push cpu_wdata[7:0]; R: 0
//   1 STATUS  R: {cnt[$clog2(FIFO_DEPTH):0] at [15:8], overflow[3], busy[2], empty[1], full[0]}
//             W: any value clears overflow
//   2,3       R: 0; W: ignored
//  Reset: tx=1, irq_tx_empty=1, FIFO empty, overflow=0, FSM IDLE, baud/bit counters 0.
//  Push: write_enable & offset 0 & !full (registered full) -> byte enqueued at clock edge.
//   Push while full -> byte dropped, overflow set (sticky), even if a pop occurs the same cycle.
//  Read: cpu_rdata is combinational from current registered state (same-cycle load result).
//  FSM states IDLE, START, DATA, STOP (enum in package):
//   IDLE : tx=1; if !empty -> pop head into shift reg, go START next edge.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA : tx=shift[0] (LSB first) for CLKS_PER_BIT cycles; shift right; after bit 7 -> STOP
//          (or PARITY with UART_PARITY_EN).
//   STOP : tx=1 for CLKS_PER_BIT cycles; then if !empty pop and go START directly (no idle gap),
//          else IDLE.
//  Frame length exactly 10*CLKS_PER_BIT cycles; first tx low the cycle after the pop edge.
//  busy=1 in any state but IDLE. Push and pop in the same cycle: cnt unchanged, both take effect.
//  Baud counter counts 0..CLKS_PER_BIT-1, wraps; width $clog2(CLKS_PER_BIT).
//  FIFO pointers $clog2(FIFO_DEPTH) bits, wrap naturally; cnt one bit wider.
//  reset mid-frame: tx returns high the next edge, FIFO contents discarded, no partial bits resumed.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state between DATA and STOP, tx = ^byte (even parity) for
//   CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT; STATUS[4] reads 1.
//  Not defined: 8N1 only, no PARITY state, STATUS[4] reads 0.
// STRUCTURE
//  Package uart_pkg: tx_state_e enum, register offsets (UART_TXDATA_OFS, UART_STATUS_OFS),
//   STATUS bit indices.
//  Sub-module sync_fifo (DATA_WIDTH 8, DEPTH FIFO_DEPTH): push/pop/full/empty/cnt, synchronous reset.
//  Top holds address decode, overflow flag, baud counter and serialiser FSM.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset then read STATUS -> cpu_rdata=0x00000002, tx=1, irq_tx_empty=1.
//  2 Write 0xA5 to offset 0 -> tx samples (mid-bit) 0,1,0,1,0,0,1,0,1,1; 40 cycles; then irq_tx_empty=1.
//  3 Write 0x01,0x02 back-to-back -> second start bit follows first stop bit with zero idle cycles.
//  4 Write 6 bytes in 6 consecutive cycles -> first popped into shifter, 4 queued, 6th dropped;
//    STATUS full=1, overflow=1; write STATUS clears overflow only.
//  5 Assert reset at cycle 17 of a frame -> tx=1 next edge, STATUS=0x2, no further frame.
//  6 UART_PARITY_EN, write 0x07 -> parity bit 1 after bit 7; frame 44 cycles; STATUS[4]=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and register map for mmio_uart_tx.
// UART_PARITY_EN adds the even-parity frame state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] UART_TXDATA_OFS = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_PAR_BIT   = 4;
  localparam int STAT_CNT_LSB   = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally; count tracks push/pop balance
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus UART transmitter, 8N1 by default.
// Define UART_PARITY_EN for an even-parity bit before stop.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  tx,
  output logic                  irq_tx_empty
);

  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]            offset;
  logic                  wr_txdata;
  logic                  wr_status;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [7:0]            fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] status;
  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [BW-1:0]         baud_q;
  logic [BW-1:0]         baud_d;
  logic [2:0]            bit_q;
  logic [2:0]            bit_d;
  logic [7:0]            shift_q;
  logic [7:0]            shift_d;
  logic                  baud_end;
  logic                  busy;
  logic                  unused_addr;
  logic                  unused_wdata;

`ifdef UART_PARITY_EN
  logic                  par_q;
`endif

  assign offset       = cpu_address[3:2];
  assign unused_addr  = ^{cpu_address[ADDR_WIDTH-1:4],
                          cpu_address[1:0]};
  assign unused_wdata = ^cpu_wdata[DATA_WIDTH-1:8];

  // register-map decode for stores
  always_comb begin
    wr_txdata = 1'b0;
    wr_status = 1'b0;
    if (write_enable) begin
      unique case (offset)
        UART_TXDATA_OFS: wr_txdata = 1'b1;
        UART_STATUS_OFS: wr_status = 1'b1;
        default:         ;
      endcase
    end
  end

  assign fifo_push = wr_txdata & ~fifo_full;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cpu_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (fifo_cnt)
  );

  // sticky overflow: a store to a full FIFO drops its byte
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (wr_status) begin
      ovf_q <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign irq_tx_empty = fifo_empty & ~busy;
  assign baud_end     = (baud_q == BAUD_LAST);

  // STATUS word assembled from live state
  always_comb begin
    status                       = '0;
    status[STAT_CNT_LSB +: CW]   = fifo_cnt;
    status[STAT_OVF_BIT]         = ovf_q;
    status[STAT_BUSY_BIT]        = busy;
    status[STAT_EMPTY_BIT]       = fifo_empty;
    status[STAT_FULL_BIT]        = fifo_full;
`ifdef UART_PARITY_EN
    status[STAT_PAR_BIT]         = 1'b1;
`endif
  end

  // same-cycle load data; zero unless STATUS is read
  always_comb begin
    cpu_rdata = '0;
    if (read_enable && offset == UART_STATUS_OFS) begin
      cpu_rdata = status;
    end
  end

  // serialiser state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_PARITY_EN
  // even parity latched with the byte as it leaves the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (fifo_pop) begin
      par_q <= ^fifo_dout;
    end
  end
`endif

  // next-state: each non-idle state lasts one full bit time
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // line level decoded from the current state
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_q[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx = par_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random store bursts for mmio_uart_tx.
// A line monitor decodes frames; a byte-level model predicts them.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = 10 + PAR;
  localparam int FL = CPB * FB;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] cpu_rdata;
  logic        tx;
  logic        irq_tx_empty;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .cpu_rdata    (cpu_rdata),
    .tx           (tx),
    .irq_tx_empty (irq_tx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int rst_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [10:0] rx_bits[$];
  int          rx_start[$];
  int          rx_head = 0;
  logic [7:0]  wr_q[$];
  logic [7:0]  exp_q[$];

  // line monitor: mid-bit samples of every frame not cut by reset
  initial begin
    logic [10:0] bits;
    int st;
    int rs;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        st   = cyc;
        rs   = rst_cnt;
        bits = '1;
        for (int k = 0; k < FB; k++) begin
          repeat ((k == 0) ? 2 : CPB) @(negedge clk);
          bits[k] = tx;
        end
        @(negedge clk);
        if (rs == rst_cnt) begin
          rx_bits.push_back(bits);
          rx_start.push_back(st);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected line samples: start, LSB first, parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (PAR != 0) f[9] = ^b;
    return f;
  endfunction

  function automatic logic [31:0] stat_of(input int cnt, input bit ovf,
                                          input bit busy);
    logic [31:0] s;
    s    = 32'(cnt) << 8;
    s[4] = (PAR != 0);
    s[3] = ovf;
    s[2] = busy;
    s[1] = (cnt == 0);
    s[0] = (cnt == DEPTH);
    return s;
  endfunction

  task automatic rd(input logic [1:0] ofs, input logic re,
                    output logic [31:0] v);
    @(negedge clk);
    cpu_address = ($urandom & 32'hFFFF_FFF3) | {28'd0, ofs, 2'b00};
    read_enable = re;
    #1 v = cpu_rdata;
    read_enable = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ofs, input logic [31:0] d);
    @(negedge clk);
    cpu_address  = ($urandom & 32'hFFFF_FFF3) | {28'd0, ofs, 2'b00};
    cpu_wdata    = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // consecutive TXDATA stores of wr_q; p = cycle of first push edge
  task automatic burst(input int n, output int p);
    p = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) p = cyc + 1;
      cpu_address  = $urandom & 32'hFFFF_FFF3;
      cpu_wdata    = {$urandom_range(0, 32'hFF_FFFF), wr_q[i]};
      cpu_wdata[7:0] = wr_q[i];
      write_enable = 1'b1;
      if (i < DEPTH + 1) exp_q.push_back(wr_q[i]);
    end
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (irq_tx_empty !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(irq_tx_empty), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames(input int p, input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, rx_bits.size() - rx_head, n);
    for (int k = 0; k < n && rx_head < rx_bits.size(); k++) begin
      chk({tag, "_bits"}, 32'(rx_bits[rx_head]), 32'(frame_of(exp_q[k])));
      chk({tag, "_start"}, rx_start[rx_head], p + 1 + FL * k);
      rx_head++;
    end
  endtask

  initial begin
    logic [31:0] v;
    int p;
    int n;
    reset        = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    cpu_address  = '0;
    cpu_wdata    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    rd(2'd1, 1'b1, v);
    chk("rst_status", v, stat_of(0, 0, 0));
    chk("rst_tx", 32'(tx), 1);
    chk("rst_irq", 32'(irq_tx_empty), 1);

    // single byte, exact frame length
    wr_q = '{8'hA5};
    burst(1, p);
    while (cyc < p + FL) @(negedge clk);
    chk("a5_irq_last", 32'(irq_tx_empty), 0);
    @(negedge clk);
    chk("a5_irq_done", 32'(irq_tx_empty), 1);
    repeat (3) @(negedge clk);
    check_frames(p, "a5");

    // back-to-back frames, no idle gap
    wr_q = '{8'h01, 8'h02};
    burst(2, p);
    wait_idle();
    check_frames(p, "b2b");

    // parity-sensitive byte
    wr_q = '{8'h07};
    burst(1, p);
    wait_idle();
    check_frames(p, "x07");

    // overflow: 6 stores into shifter + 4-deep FIFO
    wr_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    burst(6, p);
    rd(2'd1, 1'b1, v);
    chk("ovf_status", v, stat_of(DEPTH, 1, 1));
    wr(2'd1, $urandom);
    rd(2'd1, 1'b1, v);
    chk("ovf_clear", v, stat_of(DEPTH, 0, 1));
    wait_idle();
    check_frames(p, "ovf");

    // reset in the middle of a frame
    wr_q = '{8'h3C};
    burst(1, p);
    while (cyc < p + 1 + 16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_tx", 32'(tx), 1);
    chk("mrst_irq", 32'(irq_tx_empty), 1);
    reset = 1'b0;
    rd(2'd1, 1'b1, v);
    chk("mrst_status", v, stat_of(0, 0, 0));
    repeat (60) @(negedge clk);
    chk("mrst_noframe", rx_bits.size(), rx_head);

    // non-STATUS reads and disabled reads return zero
    rd(2'd0, 1'b1, v);
    chk("rd_txdata", v, 0);
    rd(2'd2, 1'b1, v);
    chk("rd_ofs2", v, 0);
    rd(2'd1, 1'b0, v);
    chk("rd_off", v, 0);

    // ignored store to offset 3
    wr(2'd3, $urandom);
    rd(2'd1, 1'b1, v);
    chk("wr_ofs3", v, stat_of(0, 0, 0));

    // random bursts from idle
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, DEPTH + 1);
      wr_q.delete();
      for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      burst(n, p);
      rd(2'd1, 1'b1, v);
      chk("rnd_status", v, stat_of(n - 1, 0, 1));
      wait_idle();
      check_frames(p, "rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
